// File: rtl/subservient_loader_pkg.sv
// Shared state encodings and small helpers for the UART boot loader.
package subservient_loader_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_FIRST,
        ST_COLLECT,
        ST_WRITE,
        ST_PAD,
        ST_FINISH,
        ST_DONE
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_idx);
        return {byte_idx[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] w;
        w = word;
        w[lane*8 +: 8] = data;
        return w;
    endfunction

endpackage

// File: rtl/subservient_uart_loader_if.sv
// Wishbone debug write channel between the loader and the SoC memory port.
interface subservient_uart_loader_if;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic        ack;

    modport master (output adr, dat, sel, we, stb, input ack);
    modport slave  (input adr, dat, sel, we, stb, output ack);
endinterface

// File: rtl/subservient_uart_rx.sv
// 8N1 UART receiver: synchronizes rx, confirms the start bit at mid-bit, then samples once per bit.
module subservient_uart_rx
    import subservient_loader_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_frame_err
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLK_DIV - 1);

    rx_state_e     state_q, state_d;
    logic          meta_q, meta_d;
    logic          sync_q, sync_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;

    always_comb begin
        meta_d  = i_rx;
        sync_d  = meta_q;
        prev_d  = sync_q;
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (sync_q) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_LOAD;
                        bit_d   = 3'd0;
                    end
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    data_d = {sync_q, data_q[7:1]};
                    cnt_d  = FULL_LOAD;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    valid_d = sync_q;
                    ferr_d  = !sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= RX_IDLE;
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_frame_err = ferr_q;

endmodule

// File: rtl/subservient_uart_loader.sv
// Receives a firmware image over UART and writes it word by word into SRAM through Wishbone.
//
// state        | meaning
// WAIT_FIRST   | no byte seen yet, idle timer stopped
// COLLECT      | packing bytes into the current word, idle timer running
// WRITE        | full word on the bus, waiting for ack
// PAD          | writing the final partial word with upper lanes zero
// FINISH       | one cycle: release debug mode, raise done
// DONE         | terminal until reset
module subservient_uart_loader
    import subservient_loader_pkg::*;
#(
    parameter int CLK_DIV      = 868,
    parameter int MEMSIZE      = 8192,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rx,
    output logic [31:0]               o_wb_adr,
    output logic [31:0]               o_wb_dat,
    output logic [3:0]                o_wb_sel,
    output logic                      o_wb_we,
    output logic                      o_wb_stb,
    input  logic                      i_wb_ack,
    output logic                      o_debug_mode,
    output logic                      o_done,
    output logic [$clog2(MEMSIZE):0]  o_byte_count,
    output logic                      o_err_ovf,
    output logic                      o_err_frame
);

    localparam int AW  = $clog2(MEMSIZE);
    localparam int TMO = TIMEOUT_BITS * CLK_DIV;
    localparam int TW  = $clog2(TMO + 1);
    localparam logic [TW-1:0] TMO_LOAD  = TW'(TMO - 1);
    localparam logic [AW:0]   MEM_BYTES = (AW+1)'(MEMSIZE);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    subservient_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rx        (i_rx),
        .o_valid     (rx_valid),
        .o_data      (rx_data),
        .o_frame_err (rx_ferr)
    );

    loader_state_e state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   wb_adr_q, wb_adr_d;
    logic [31:0]   wb_dat_q, wb_dat_d;
    logic [AW:0]   count_q, count_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          buf_valid_q, buf_valid_d;
    logic [7:0]    buf_data_q, buf_data_d;
    logic          ovf_q, ovf_d;
    logic          ferr_q, ferr_d;

    logic          take;
    logic [7:0]    take_byte;
    logic [31:0]   word_ins;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        wb_adr_d    = wb_adr_q;
        wb_dat_d    = wb_dat_q;
        count_d     = count_q;
        timer_d     = timer_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        ovf_d       = ovf_q;
        ferr_d      = ferr_q;
        take        = 1'b0;
        take_byte   = rx_data;
        word_ins    = word_q;

        case (state_q)
            ST_WAIT_FIRST: begin
                if (rx_valid) begin
                    take    = 1'b1;
                    timer_d = TMO_LOAD;
                end
            end
            ST_COLLECT: begin
                // A byte parked during the last write goes first; a new arrival takes its slot.
                if (buf_valid_q) begin
                    take        = 1'b1;
                    take_byte   = buf_data_q;
                    buf_valid_d = rx_valid;
                    if (rx_valid) buf_data_d = rx_data;
                end else if (rx_valid) begin
                    take = 1'b1;
                end
                if (rx_valid) begin
                    timer_d = TMO_LOAD;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - 1'b1;
                end
                if (!take && timer_q == '0) begin
                    wb_adr_d = word_addr(32'(count_q));
                    wb_dat_d = word_q;
                    state_d  = (count_q[1:0] != 2'b00) ? ST_PAD : ST_FINISH;
                end
            end
            ST_WRITE, ST_PAD: begin
                if (rx_valid) begin
                    timer_d = TMO_LOAD;
                    if (buf_valid_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        buf_valid_d = 1'b1;
                        buf_data_d  = rx_data;
                    end
                end
                if (i_wb_ack) state_d = (state_q == ST_WRITE) ? ST_COLLECT : ST_FINISH;
            end
            ST_FINISH: state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_WAIT_FIRST;
        endcase

        if (take) begin
            state_d = ST_COLLECT;
            if (count_q >= MEM_BYTES) begin
                ovf_d = 1'b1;
            end else begin
                word_ins = lane_insert(word_q, count_q[1:0], take_byte);
                count_d  = count_q + 1'b1;
                if (count_q[1:0] == 2'b11) begin
                    wb_adr_d = word_addr(32'(count_q));
                    wb_dat_d = word_ins;
                    word_d   = '0;
                    state_d  = ST_WRITE;
                end else begin
                    word_d = word_ins;
                end
            end
        end

        if (rx_ferr && !(state_q inside {ST_FINISH, ST_DONE})) ferr_d = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_WAIT_FIRST;
            word_q      <= '0;
            wb_adr_q    <= '0;
            wb_dat_q    <= '0;
            count_q     <= '0;
            timer_q     <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            ovf_q       <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            wb_adr_q    <= wb_adr_d;
            wb_dat_q    <= wb_dat_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            ovf_q       <= ovf_d;
            ferr_q      <= ferr_d;
        end
    end

    assign o_wb_stb     = (state_q == ST_WRITE) || (state_q == ST_PAD);
    assign o_wb_we      = o_wb_stb;
    assign o_wb_sel     = o_wb_stb ? 4'hF : 4'h0;
    assign o_wb_adr     = wb_adr_q;
    assign o_wb_dat     = wb_dat_q;
    assign o_done       = (state_q == ST_FINISH) || (state_q == ST_DONE);
    assign o_debug_mode = !o_done;
    assign o_byte_count = count_q;
    assign o_err_ovf    = ovf_q;
    assign o_err_frame  = ferr_q;

endmodule

// File: tb/tb_subservient_uart_loader.sv
// Bench for the UART loader: UART byte driver, Wishbone slave with scoreboard, scenario tasks.
module tb_subservient_uart_loader;

    localparam int CLK_DIV      = 4;
    localparam int MEMSIZE      = 16;
    localparam int TIMEOUT_BITS = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       debug_mode;
    logic       done;
    logic [4:0] byte_count;
    logic       err_ovf;
    logic       err_frame;

    int checks = 0;
    int errors = 0;
    int ack_delay = 2;
    int ack_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    always #5 clk = ~clk;

    subservient_uart_loader_if wb ();

    subservient_uart_loader #(
        .CLK_DIV      (CLK_DIV),
        .MEMSIZE      (MEMSIZE),
        .TIMEOUT_BITS (TIMEOUT_BITS)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx         (rx),
        .o_wb_adr     (wb.adr),
        .o_wb_dat     (wb.dat),
        .o_wb_sel     (wb.sel),
        .o_wb_we      (wb.we),
        .o_wb_stb     (wb.stb),
        .i_wb_ack     (wb.ack),
        .o_debug_mode (debug_mode),
        .o_done       (done),
        .o_byte_count (byte_count),
        .o_err_ovf    (err_ovf),
        .o_err_frame  (err_frame)
    );

    // Wishbone slave: acks ack_delay cycles after stb and checks each write against the scoreboard.
    initial begin
        wb.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (!wb.stb) begin
                ack_cnt = 0;
                wb.ack  = 1'b0;
            end else if (wb.ack) begin
                ack_cnt = 0;
                wb.ack  = 1'b0;
            end else begin
                ack_cnt++;
                if (ack_cnt >= ack_delay) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL wb_write: got adr=%h dat=%h, required no write", wb.adr, wb.dat);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if ({wb.adr, wb.dat, wb.sel, wb.we} !== {exp_e, 4'hF, 1'b1}) begin
                            errors++;
                            $display("FAIL wb_write: got adr=%h dat=%h sel=%h we=%b, required adr=%h dat=%h sel=f we=1",
                                     wb.adr, wb.dat, wb.sel, wb.we, exp_e[63:32], exp_e[31:0]);
                        end
                    end
                    wb.ack = 1'b1;
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        cycles(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CLK_DIV);
        end
        rx = stop_bit;
        cycles(CLK_DIV);
        rx = 1'b1;
        if (!stop_bit) cycles(2 * CLK_DIV);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        cycles(1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 2000) begin
            cycles(1);
            n++;
        end
        checks++;
        if (done !== 1'b1 || debug_mode !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got done=%b debug=%b, required done=1 debug=0", name, done, debug_mode);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: got %0d writes outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({debug_mode, done, wb.stb, wb.we, wb.sel, wb.adr, wb.dat, byte_count, err_ovf, err_frame}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got debug=%b done=%b stb=%b we=%b sel=%h adr=%h dat=%h cnt=%0d ovf=%b ferr=%b, required 1 0 0 0 0 0 0 0 0 0",
                     debug_mode, done, wb.stb, wb.we, wb.sel, wb.adr, wb.dat, byte_count, err_ovf, err_frame);
        end
        rx = 1'b0;
        cycles(1);
        rx = 1'b1;
        cycles(300);
        checks++;
        if ({byte_count, err_frame, done, debug_mode} !== {5'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL glitch_idle: got cnt=%0d ferr=%b done=%b debug=%b, required 0 0 0 1",
                     byte_count, err_frame, done, debug_mode);
        end
    endtask

    task automatic test_single_word();
        do_reset();
        exp_q.push_back({32'h0, 32'h0000_0513});
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        wait_done("single");
        checks++;
        if (byte_count !== 5'd4 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_count: got cnt=%0d ovf=%b, required 4 0", byte_count, err_ovf);
        end
        send_byte(8'h77, 1'b0);
        send_byte(8'h78, 1'b1);
        cycles(100);
        checks++;
        if ({byte_count, err_frame, err_ovf, done} !== {5'd4, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL done_ignores: got cnt=%0d ferr=%b ovf=%b done=%b, required 4 0 0 1",
                     byte_count, err_frame, err_ovf, done);
        end
    endtask

    task automatic test_pad();
        do_reset();
        exp_q.push_back({32'h0, 32'h0403_0201});
        exp_q.push_back({32'h4, 32'h0000_0605});
        for (int i = 1; i <= 6; i++) send_byte(8'(i), 1'b1);
        cycles(4);
        checks++;
        if (byte_count !== 5'd6 || done !== 1'b0) begin
            errors++;
            $display("FAIL pad_pre_timeout: got cnt=%0d done=%b, required 6 0", byte_count, done);
        end
        wait_done("pad");
        checks++;
        if (byte_count !== 5'd6) begin
            errors++;
            $display("FAIL pad_count: got %0d, required 6", byte_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int w = 0; w < 4; w++) begin
            exp_q.push_back({32'(w * 4),
                             8'(8'h23 + w * 4), 8'(8'h22 + w * 4), 8'(8'h21 + w * 4), 8'(8'h20 + w * 4)});
        end
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i), 1'b1);
        cycles(8);
        checks++;
        if (byte_count !== 5'd16 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_at_limit: got cnt=%0d ovf=%b, required 16 0", byte_count, err_ovf);
        end
        send_byte(8'h30, 1'b1);
        send_byte(8'h31, 1'b1);
        cycles(4);
        checks++;
        if (byte_count !== 5'd16 || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_past_limit: got cnt=%0d ovf=%b, required 16 1", byte_count, err_ovf);
        end
        wait_done("ovf");
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        ack_delay = 200;
        exp_q.push_back({32'h0, 32'h1312_1110});
        exp_q.push_back({32'h4, 32'hB3B2_B1A0});
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b1);
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        cycles(4);
        checks++;
        if ({wb.stb, byte_count, err_ovf} !== {1'b1, 5'd4, 1'b1}) begin
            errors++;
            $display("FAIL stall_drop: got stb=%b cnt=%0d ovf=%b, required 1 4 1", wb.stb, byte_count, err_ovf);
        end
        while (wb.stb && n < 400) begin
            cycles(1);
            n++;
        end
        ack_delay = 2;
        checks++;
        if (wb.stb !== 1'b0) begin
            errors++;
            $display("FAIL stall_ack: got stb=%b after 400 cycles, required 0", wb.stb);
        end
        cycles(2);
        checks++;
        if (byte_count !== 5'd5) begin
            errors++;
            $display("FAIL held_byte: got cnt=%0d, required 5", byte_count);
        end
        send_byte(8'hB1, 1'b1);
        send_byte(8'hB2, 1'b1);
        send_byte(8'hB3, 1'b1);
        wait_done("b2b");
        checks++;
        if (byte_count !== 5'd8 || err_ovf !== 1'b1) begin
            errors++;
            $display("FAIL b2b_count: got cnt=%0d ovf=%b, required 8 1", byte_count, err_ovf);
        end
    endtask

    task automatic test_frame_err();
        do_reset();
        send_byte(8'h55, 1'b0);
        checks++;
        if (byte_count !== 5'd0 || err_frame !== 1'b1) begin
            errors++;
            $display("FAIL frame_err: got cnt=%0d ferr=%b, required 0 1", byte_count, err_frame);
        end
        exp_q.push_back({32'h0, 32'h0000_0066});
        send_byte(8'h66, 1'b1);
        cycles(4);
        checks++;
        if (byte_count !== 5'd1) begin
            errors++;
            $display("FAIL frame_recover: got cnt=%0d, required 1", byte_count);
        end
        wait_done("frame");
        checks++;
        if (err_frame !== 1'b1 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL frame_sticky: got ferr=%b ovf=%b, required 1 0", err_frame, err_ovf);
        end
    endtask

    task automatic test_reset_mid_write();
        int n = 0;
        logic seen_stb = 1'b0;
        do_reset();
        ack_delay = 200;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b1);
        while (!wb.stb && n < 100) begin
            cycles(1);
            n++;
        end
        checks++;
        if (wb.stb !== 1'b1) begin
            errors++;
            $display("FAIL rst_write_pending: got stb=%b, required 1", wb.stb);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({wb.stb, wb.we, wb.sel, wb.adr, wb.dat, debug_mode, byte_count}
            !== {1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 5'd0}) begin
            errors++;
            $display("FAIL rst_mid_write: got stb=%b we=%b sel=%h adr=%h dat=%h debug=%b cnt=%0d, required 0 0 0 0 0 1 0",
                     wb.stb, wb.we, wb.sel, wb.adr, wb.dat, debug_mode, byte_count);
        end
        cycles(1);
        rst = 1'b0;
        ack_delay = 2;
        for (int i = 0; i < 60; i++) begin
            cycles(1);
            if (wb.stb) seen_stb = 1'b1;
        end
        checks++;
        if (seen_stb !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_retry: got stb seen=%b, required 0", seen_stb);
        end
        exp_q.push_back({32'h0, 32'h4433_2211});
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        wait_done("rst_fresh");
        checks++;
        if (byte_count !== 5'd4 || err_ovf !== 1'b0 || err_frame !== 1'b0) begin
            errors++;
            $display("FAIL rst_fresh_count: got cnt=%0d ovf=%b ferr=%b, required 4 0 0",
                     byte_count, err_ovf, err_frame);
        end
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        cycles(3);
        test_reset();
        test_single_word();
        test_pad();
        test_overflow();
        test_back_to_back();
        test_frame_err();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
